// File: rtl/axis_upsample.sv
// rtl/axis_upsample.sv - 1-bit AXI-Stream symbol repeater, OVS_FACTOR copies per input beat (option macro: AXIS_UPSAMPLE_LAST_ALL_EN)
module axis_upsample #(
  parameter int OVS_FACTOR = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic s_axis_tdata,
  input  logic s_axis_tvalid,
  input  logic s_axis_tlast,
  output logic s_axis_tready,
  output logic m_axis_tdata,
  output logic m_axis_tvalid,
  output logic m_axis_tlast,
  output logic m_axis_tuser,
  input  logic m_axis_tready
);

  localparam int CW = $clog2(OVS_FACTOR);
  localparam logic [CW-1:0] LAST_CNT = CW'(OVS_FACTOR - 1);

  if (OVS_FACTOR < 2 || OVS_FACTOR > 16) begin : g_bad_ovs
    $error("axis_upsample: OVS_FACTOR must be in 2..16");
  end

  // symbol being replayed and the single pending symbol behind it
  logic          cur_vld, cur_data, cur_last;
  logic          nxt_vld, nxt_data, nxt_last;
  logic [CW-1:0] rep_cnt;

  logic          cur_vld_d, cur_data_d, cur_last_d;
  logic          nxt_vld_d, nxt_data_d, nxt_last_d;
  logic [CW-1:0] rep_cnt_d;

  logic accept, out_beat, final_beat;

  assign accept     = s_axis_tvalid & s_axis_tready;
  assign out_beat   = cur_vld & m_axis_tready;
  assign final_beat = out_beat & (rep_cnt == LAST_CNT);

  // next-state: refill cur from pending first, else straight from the input so no bubble appears
  always_comb begin
    cur_vld_d  = cur_vld;
    cur_data_d = cur_data;
    cur_last_d = cur_last;
    nxt_vld_d  = nxt_vld;
    nxt_data_d = nxt_data;
    nxt_last_d = nxt_last;
    rep_cnt_d  = rep_cnt;
    if (!cur_vld) begin
      if (accept) begin
        cur_vld_d  = 1'b1;
        cur_data_d = s_axis_tdata;
        cur_last_d = s_axis_tlast;
        rep_cnt_d  = '0;
      end
    end else if (final_beat) begin
      rep_cnt_d = '0;
      if (nxt_vld) begin
        cur_data_d = nxt_data;
        cur_last_d = nxt_last;
        nxt_vld_d  = 1'b0;
      end else if (accept) begin
        cur_data_d = s_axis_tdata;
        cur_last_d = s_axis_tlast;
      end else begin
        cur_vld_d = 1'b0;
      end
    end else begin
      if (out_beat) begin
        rep_cnt_d = rep_cnt + CW'(1);
      end
      if (accept) begin
        nxt_vld_d  = 1'b1;
        nxt_data_d = s_axis_tdata;
        nxt_last_d = s_axis_tlast;
      end
    end
  end

  // state registers; tready is registered from the pending slot so it never sees m_axis_tready combinationally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cur_vld       <= 1'b0;
      cur_data      <= 1'b0;
      cur_last      <= 1'b0;
      nxt_vld       <= 1'b0;
      nxt_data      <= 1'b0;
      nxt_last      <= 1'b0;
      rep_cnt       <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      cur_vld       <= cur_vld_d;
      cur_data      <= cur_data_d;
      cur_last      <= cur_last_d;
      nxt_vld       <= nxt_vld_d;
      nxt_data      <= nxt_data_d;
      nxt_last      <= nxt_last_d;
      rep_cnt       <= rep_cnt_d;
      s_axis_tready <= ~nxt_vld_d;
    end
  end

  // output stream: every copy carries the symbol; tlast on all copies or only the final one
  always_comb begin
    m_axis_tvalid = cur_vld;
    m_axis_tdata  = cur_data;
    m_axis_tuser  = 1'b0;
`ifdef AXIS_UPSAMPLE_LAST_ALL_EN
    m_axis_tlast  = cur_last;
`else
    m_axis_tlast  = cur_last & (rep_cnt == LAST_CNT);
`endif
  end

endmodule

// File: tb/tb_axis_upsample.sv
// tb/tb_axis_upsample.sv - self-checking bench for axis_upsample
module tb_axis_upsample;

  localparam int OVS = 4;
`ifdef AXIS_UPSAMPLE_LAST_ALL_EN
  localparam bit LAST_ALL = 1'b1;
`else
  localparam bit LAST_ALL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic s_tdata, s_tvalid, s_tlast, s_tready;
  logic m_tdata, m_tvalid, m_tlast, m_tuser, m_tready;
  logic ready_val, rand_mode, rnd_bit;

  assign m_tready = rand_mode ? rnd_bit : ready_val;

  axis_upsample #(.OVS_FACTOR(OVS)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .m_axis_tready (m_tready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic d;
    logic l;
  } beat_t;

  beat_t sb[$];
  logic  dec_q[$];
  logic  dec_l[$];
  int    beat_cyc[$];
  int    beat_cnt = 0;
  int    cyc = 0;
  bit    prev_up = 0;
  bit    stall_prev = 0;
  logic  st_d, st_l;
  int    grp_n = 0;
  int    grp_ones = 0;
  logic  grp_last = 1'b0;

  // monitor / scoreboard: evaluated at the falling edge, describing the handshakes of the next rising edge
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_up    = 0;
      stall_prev = 0;
      grp_n      = 0;
      grp_ones   = 0;
      grp_last   = 1'b0;
    end else begin
      if (prev_up)
        chk("s_tready_vs_pending", int'(s_tready), int'(((sb.size() + OVS - 1) / OVS) < 2));
      if (stall_prev) begin
        chk("stall_tvalid", int'(m_tvalid), 1);
        chk("stall_tdata", int'(m_tdata), int'(st_d));
        chk("stall_tlast", int'(m_tlast), int'(st_l));
      end
      if (m_tvalid && m_tready) begin
        beat_cnt++;
        beat_cyc.push_back(cyc);
        chk("beat_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_tdata", int'(m_tdata), int'(e.d));
          chk("beat_tlast", int'(m_tlast), int'(e.l));
        end
        grp_ones += int'(m_tdata);
        grp_last |= m_tlast;
        grp_n++;
        if (grp_n == OVS) begin
          dec_q.push_back(grp_ones * 2 > OVS);
          dec_l.push_back(grp_last);
          grp_n    = 0;
          grp_ones = 0;
          grp_last = 1'b0;
        end
      end
      if (s_tvalid && s_tready) begin
        for (int j = 0; j < OVS; j++) begin
          beat_t e;
          e.d = s_tdata;
          e.l = s_tlast && (LAST_ALL || j == OVS - 1);
          sb.push_back(e);
        end
      end
      stall_prev = m_tvalid && !m_tready;
      st_d       = m_tdata;
      st_l       = m_tlast;
      prev_up    = 1;
    end
  end

  typedef struct {
    logic rst_n, s_v, s_d, s_l, m_r;
    logic e_v, e_d, e_l_fin, e_l_all, e_sr;
  } vec_t;

  vec_t vt[$];

  task automatic row(input logic r, input logic sv, input logic sd, input logic sl, input logic mr,
                     input logic ev, input logic ed, input logic elf, input logic ela, input logic esr);
    vec_t v;
    v = '{r, sv, sd, sl, mr, ev, ed, elf, ela, esr};
    vt.push_back(v);
  endtask

  task automatic send_beat(input string name);
    bit hs = 0;
    for (int w = 0; w < 200 && !hs; w++) begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      #1;
    end
    if (!hs) chk({name, "_accept_timeout"}, 0, 1);
  endtask

  task automatic drain(input string name);
    bit ok = 0;
    for (int w = 0; w < 500 && !ok; w++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !m_tvalid) ok = 1;
    end
    chk({name, "_drain"}, int'(ok), 1);
  endtask

  task automatic run_stream(input string name, input logic [12:0] pat, input bit rnd);
    int b0;
    logic [12:0] got;
    int nlast;
    rand_mode = rnd;
    ready_val = 1'b1;
    dec_q.delete();
    dec_l.delete();
    beat_cyc.delete();
    b0 = beat_cnt;
    for (int i = 12; i >= 0; i--) begin
      s_tvalid = 1'b1;
      s_tdata  = pat[i];
      s_tlast  = (i == 0);
      send_beat(name);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    drain(name);
    rand_mode = 1'b0;
    chk({name, "_beats"}, beat_cnt - b0, 13 * OVS);
    chk({name, "_symbols"}, dec_q.size(), 13);
    got   = '0;
    nlast = 0;
    for (int i = 0; i < dec_q.size(); i++) begin
      got = {got[11:0], dec_q[i]};
      nlast += int'(dec_l[i]);
    end
    chk({name, "_pattern"}, int'(got), int'(pat));
    chk({name, "_tlast_count"}, nlast, 1);
    if (dec_l.size() == 13) chk({name, "_tlast_on_13th"}, int'(dec_l[12]), 1);
    if (!rnd && beat_cyc.size() == 13 * OVS)
      chk({name, "_no_gap"}, beat_cyc[13 * OVS - 1] - beat_cyc[0], 13 * OVS - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b1;
    bit hs, done;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = 1'b0; s_tlast = 1'b0;
    ready_val = 1'b1; rand_mode = 1'b0;

    //   rst sv sd sl mr | ev ed lfin lall sr
    for (int i = 0; i < 5; i++) row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    row(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    row(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    row(1, 1, 1, 0, 1, 1, 1, 0, 0, 1);
    row(1, 0, 0, 0, 1, 1, 1, 0, 0, 1);
    row(1, 0, 0, 0, 1, 1, 1, 0, 0, 1);
    row(1, 0, 0, 0, 1, 1, 1, 0, 0, 1);
    row(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    row(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    row(1, 1, 0, 1, 0, 1, 0, 0, 1, 1);
    row(1, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    row(1, 0, 0, 0, 1, 1, 0, 0, 1, 1);
    row(1, 0, 0, 0, 1, 1, 0, 0, 1, 1);
    row(1, 0, 0, 0, 1, 1, 0, 1, 1, 1);
    row(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    row(1, 1, 1, 0, 0, 1, 1, 0, 0, 1);
    row(1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    row(1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    row(1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    row(1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    row(1, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    row(1, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    row(1, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    row(1, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    row(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);

    for (int i = 0; i < vt.size(); i++) begin
      rst_n     = vt[i].rst_n;
      s_tvalid  = vt[i].s_v;
      s_tdata   = vt[i].s_d;
      s_tlast   = vt[i].s_l;
      ready_val = vt[i].m_r;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_tvalid", i), int'(m_tvalid), int'(vt[i].e_v));
      if (vt[i].e_v || !vt[i].rst_n)
        chk($sformatf("vec%0d_tdata", i), int'(m_tdata), int'(vt[i].e_d));
      chk($sformatf("vec%0d_tlast", i), int'(m_tlast),
          int'(LAST_ALL ? vt[i].e_l_all : vt[i].e_l_fin));
      chk($sformatf("vec%0d_s_tready", i), int'(s_tready), int'(vt[i].e_sr));
      chk($sformatf("vec%0d_tuser", i), int'(m_tuser), 0);
    end
    s_tvalid  = 1'b0;
    ready_val = 1'b1;

    run_stream("stream", 13'b1111100110101, 1'b0);
    run_stream("bp_stream", 13'b1111100110101, 1'b1);

    // reset mid-symbol with a pending symbol queued
    b1 = beat_cnt;
    s_tvalid = 1'b1; s_tdata = 1'b1; s_tlast = 1'b0;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      #1;
      hs = s_tready;
      if (beat_cnt - b1 >= 10) done = 1;
      @(posedge clk);
      #1;
      if (hs && !done) s_tdata = ~s_tdata;
    end
    chk("midrst_reached", int'(done), 1);
    chk("midrst_pending_tready", int'(s_tready), 0);
    chk("midrst_tvalid_before", int'(m_tvalid), 1);
    #2;
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    sb.delete();
    #1;
    chk("midrst_tvalid", int'(m_tvalid), 0);
    chk("midrst_tdata", int'(m_tdata), 0);
    chk("midrst_tlast", int'(m_tlast), 0);
    chk("midrst_s_tready", int'(s_tready), 0);
    b1 = beat_cnt;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("midrst_hold_tvalid", int'(m_tvalid), 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_release_tready", int'(s_tready), 1);
    chk("midrst_no_residue", int'(m_tvalid), 0);
    chk("midrst_no_beats", beat_cnt - b1, 0);
    s_tvalid = 1'b1; s_tdata = 1'b1; s_tlast = 1'b1;
    send_beat("post_rst");
    s_tvalid = 1'b0; s_tlast = 1'b0;
    drain("post_rst");
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_beats", beat_cnt - b1, OVS);
    chk("post_rst_idle", int'(m_tvalid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
